order_queue_ctrl: RTL and testbench

Pointer and handshake controller for the 32-entry order queue memory. It turns the raw write-enable/address memory into an in-order FIFO of 5-bit instruction tags. Dispatch enqueues tags in program order; the issue/commit stage dequeues them in the same order. It sits between dispatch and issue and drives the memory's `writeEnable`/`dest`/`source`/`dataIn`, consuming its registered `dataOut`.

---
 rtl/order_queue_ctrl.sv | 115 +++++++++++
 tb/tb_order_queue_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/order_queue_ctrl.sv
// In-order FIFO controller for the 32-entry order queue memory: pointers, occupancy, handshakes.
// Optional high-water-mark output `hwm` when ORDER_QUEUE_HWM_EN is defined.
module order_queue_ctrl #(
   parameter int WIDTH        = 5,
   parameter int DEPTH        = 32,
   parameter int PTRWIDTH     = 5,
   parameter int ADDRESSWIDTH = 6
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    enq_valid,
   input  logic [WIDTH-1:0]        enq_data,
   output logic                    enq_ready,
   output logic                    deq_valid,
   output logic [WIDTH-1:0]        deq_data,
   input  logic                    deq_ready,
   input  logic                    flush,
   output logic [PTRWIDTH:0]       count,
   output logic                    mem_we,
   output logic [ADDRESSWIDTH-1:0] mem_dest,
   output logic [ADDRESSWIDTH-1:0] mem_source,
   output logic [WIDTH-1:0]        mem_data_in,
   input  logic [WIDTH-1:0]        mem_data_out,
`ifdef ORDER_QUEUE_HWM_EN
   output logic [PTRWIDTH:0]       hwm,
`endif
   output logic [1:0]              fsm_state
);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      ACTIVE = 2'd1,
      FULL   = 2'd2,
      FLUSH  = 2'd3
   } state_t;

   localparam logic [PTRWIDTH:0] FULL_COUNT = (PTRWIDTH+1)'(DEPTH);

   state_t              state, state_next;
   logic [PTRWIDTH-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
   logic [PTRWIDTH:0]   count_next, avail;
   logic                enq_fire, deq_fire;
   logic                enq_d1;

   // Handshake protocol: a transfer happens on a side in any cycle where both
   // its valid and ready are high; ready never depends on the partner's valid.
   always_comb begin
      enq_ready  = reset && (state != FULL) && (state != FLUSH) && !flush;
      // An entry written last cycle is not yet on the registered read port.
      avail      = count - {{PTRWIDTH{1'b0}}, enq_d1};
      deq_valid  = reset && !flush && ((state == ACTIVE) || (state == FULL)) && (avail != '0);
      enq_fire   = enq_valid && enq_ready;
      deq_fire   = deq_valid && deq_ready;
      rd_ptr_inc = rd_ptr + 1'b1;
      count_next = count + {{PTRWIDTH{1'b0}}, enq_fire} - {{PTRWIDTH{1'b0}}, deq_fire};
   end

   always_comb begin
      mem_we      = enq_fire;
      mem_dest    = {{(ADDRESSWIDTH-PTRWIDTH){1'b0}}, wr_ptr};
      // Address the next head so mem_data_out tracks the head one cycle later.
      mem_source  = {{(ADDRESSWIDTH-PTRWIDTH){1'b0}}, (deq_fire ? rd_ptr_inc : rd_ptr)};
      mem_data_in = enq_fire ? enq_data : '0;
      deq_data    = mem_data_out;
      fsm_state   = state;
   end

   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = FLUSH;
      end else begin
         case (state)
            EMPTY:   if (enq_fire) state_next = ACTIVE;
            ACTIVE:  if (count_next == FULL_COUNT) state_next = FULL;
                     else if (count_next == '0) state_next = EMPTY;
            FULL:    if (deq_fire) state_next = ACTIVE;
            FLUSH:   state_next = EMPTY;
            default: state_next = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state  <= EMPTY;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         enq_d1 <= 1'b0;
      end else begin
         state <= state_next;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            enq_d1 <= 1'b0;
         end else begin
            if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
            if (deq_fire) rd_ptr <= rd_ptr_inc;
            count  <= count_next;
            enq_d1 <= enq_fire;
         end
      end
   end

`ifdef ORDER_QUEUE_HWM_EN
   // Peak occupancy since reset; flush deliberately leaves it alone.
   always_ff @(posedge clock) begin
      if (!reset) hwm <= '0;
      else if (count > hwm) hwm <= count;
   end
`endif

endmodule

// File: tb/tb_order_queue_ctrl.sv
// Directed bench for order_queue_ctrl with a behavioral registered-read memory model.
// Exercises the hwm output as well when ORDER_QUEUE_HWM_EN is defined.
module tb_order_queue_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic       enq_valid;
   logic [4:0] enq_data;
   logic       enq_ready;
   logic       deq_valid;
   logic [4:0] deq_data;
   logic       deq_ready;
   logic       flush;
   logic [5:0] count;
   logic       mem_we;
   logic [5:0] mem_dest;
   logic [5:0] mem_source;
   logic [4:0] mem_data_in;
   logic [4:0] mem_data_out;
   logic [1:0] fsm_state;
`ifdef ORDER_QUEUE_HWM_EN
   logic [5:0] hwm;
`endif

   order_queue_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .enq_valid    (enq_valid),
      .enq_data     (enq_data),
      .enq_ready    (enq_ready),
      .deq_valid    (deq_valid),
      .deq_data     (deq_data),
      .deq_ready    (deq_ready),
      .flush        (flush),
      .count        (count),
      .mem_we       (mem_we),
      .mem_dest     (mem_dest),
      .mem_source   (mem_source),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out),
`ifdef ORDER_QUEUE_HWM_EN
      .hwm          (hwm),
`endif
      .fsm_state    (fsm_state)
   );

   always #5 clock = ~clock;

   // Order queue memory: write on mem_we, registered read, output cleared by reset.
   logic [4:0] mem [32];
   initial for (int i = 0; i < 32; i++) mem[i] = 5'd0;
   always @(posedge clock) begin
      if (!reset) begin
         mem_data_out <= 5'd0;
      end else begin
         mem_data_out <= mem[mem_source[4:0]];
         if (mem_we) mem[mem_dest[4:0]] <= mem_data_in;
      end
   end

   int passed = 0;
   int total  = 0;
   logic [4:0] exp_q[$];

   typedef struct {
      logic       ev;
      logic [4:0] ed;
      logic       dr;
      logic       fl;
      logic       exp_rdy;
      logic       exp_dv;
      logic [4:0] exp_data;
      int         exp_count;
      int         exp_state;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic drive(input logic ev, input logic [4:0] ed, input logic dr, input logic fl);
      @(negedge clock);
      enq_valid = ev;
      enq_data  = ed;
      deq_ready = dr;
      flush     = fl;
      #1;
   endtask

   // Drive one cycle and keep the expected queue in step with the handshakes.
   task automatic step(input logic ev, input logic [4:0] ed, input logic dr, input logic fl);
      drive(ev, ed, dr, fl);
      if (deq_valid && dr) begin
         if (exp_q.size() == 0) check("deq_unexpected", 1, 0);
         else check("deq_data", deq_data, exp_q.pop_front());
      end
      if (ev && enq_ready) exp_q.push_back(ed);
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 64 && exp_q.size() > 0; k++) step(1'b0, 5'd0, 1'b1, 1'b0);
      check(name, exp_q.size(), 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_count"}, count, 0);
      check({tag, "_state"}, fsm_state, 0);
      check({tag, "_enq_ready"}, enq_ready, 1);
      check({tag, "_deq_valid"}, deq_valid, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_mem_dest"}, mem_dest, 0);
      check({tag, "_mem_source"}, mem_source, 0);
      check({tag, "_mem_data_in"}, mem_data_in, 0);
      check({tag, "_deq_data"}, deq_data, 0);
`ifdef ORDER_QUEUE_HWM_EN
      check({tag, "_hwm"}, hwm, 0);
`endif
   endtask

   initial begin
      //          ev ed  dr fl  rdy dv data cnt st
      vecs[0] = '{1, 3,  0, 0,  1,  0, 0,   0,  0};
      vecs[1] = '{1, 7,  0, 0,  1,  0, 0,   1,  1};
      vecs[2] = '{1, 12, 0, 0,  1,  1, 3,   2,  1};
      vecs[3] = '{0, 0,  0, 0,  1,  1, 3,   3,  1};
      vecs[4] = '{0, 0,  1, 0,  1,  1, 3,   3,  1};
      vecs[5] = '{0, 0,  1, 0,  1,  1, 7,   2,  1};
      vecs[6] = '{0, 0,  1, 0,  1,  1, 12,  1,  1};
      vecs[7] = '{0, 0,  0, 0,  1,  0, 0,   0,  0};

      reset = 1'b0; enq_valid = 1'b0; enq_data = 5'd0; deq_ready = 1'b0; flush = 1'b0;
      @(negedge clock);
      enq_valid = 1'b1;
      #1;
      check("reset_enq_ready_low", enq_ready, 0);
      check("reset_mem_we_low", mem_we, 0);
      @(negedge clock);
      reset = 1'b1; enq_valid = 1'b0;
      #1;
      check_reset_values("por");

      // Basic order
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].ev, vecs[i].ed, vecs[i].dr, vecs[i].fl);
         check($sformatf("basic%0d_enq_ready", i), enq_ready, vecs[i].exp_rdy);
         check($sformatf("basic%0d_deq_valid", i), deq_valid, vecs[i].exp_dv);
         check($sformatf("basic%0d_count", i), count, vecs[i].exp_count);
         check($sformatf("basic%0d_state", i), fsm_state, vecs[i].exp_state);
         if (vecs[i].exp_dv) check($sformatf("basic%0d_deq_data", i), deq_data, vecs[i].exp_data);
      end

      // Reset mid-operation with 10 entries
      for (int i = 0; i < 10; i++) step(1'b1, 5'(10 + i), 1'b0, 1'b0);
      step(1'b0, 5'd0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 1'b0, 1'b0);
      check("midrst_count_before", count, 10);
`ifdef ORDER_QUEUE_HWM_EN
      check("midrst_hwm_before", hwm, 10);
`endif
      @(negedge clock);
      reset = 1'b0; enq_valid = 1'b1; enq_data = 5'd4;
      #1;
      check("midrst_enq_ready_low", enq_ready, 0);
      check("midrst_deq_valid_low", deq_valid, 0);
      check("midrst_mem_we_low", mem_we, 0);
      @(negedge clock);
      reset = 1'b1; enq_valid = 1'b0;
      #1;
      check_reset_values("midrst");
      exp_q.delete();
      // Reset wins over a simultaneous flush
      @(negedge clock);
      reset = 1'b0; flush = 1'b1;
      @(negedge clock);
      reset = 1'b1; flush = 1'b0;
      #1;
      check("rstflush_state", fsm_state, 0);
      check("rstflush_enq_ready", enq_ready, 1);

      // Fill to DEPTH, refuse the 33rd, then drain in order
      for (int i = 0; i < 32; i++) begin
         step(1'b1, 5'(i), 1'b0, 1'b0);
         check($sformatf("fill%0d_enq_ready", i), enq_ready, 1);
      end
      step(1'b1, 5'd5, 1'b0, 1'b0);
      check("full_count", count, 32);
      check("full_enq_ready", enq_ready, 0);
      check("full_state", fsm_state, 2);
      check("full_mem_we", mem_we, 0);
      step(1'b0, 5'd0, 1'b0, 1'b0);
      check("full_count_after_offer", count, 32);
      drain("fill_drain");
      step(1'b0, 5'd0, 1'b0, 1'b0);
      check("fill_drain_count", count, 0);
      check("fill_drain_deq_valid", deq_valid, 0);

      // Wrap: 20 single-entry round trips, then 30 queued entries
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 5'(i + 7), 1'b0, 1'b0);
         step(1'b0, 5'd0, 1'b0, 1'b0);
         step(1'b0, 5'd0, 1'b1, 1'b0);
         check($sformatf("wrap%0d_deq_valid", i), deq_valid, 1);
      end
      check("wrap_pairs_left", exp_q.size(), 0);
      for (int i = 0; i < 30; i++) step(1'b1, 5'(31 - i), 1'b0, 1'b0);
      step(1'b0, 5'd0, 1'b0, 1'b0);
      check("wrap_count", count, 30);
      drain("wrap_drain");

      // Simultaneous enqueue and dequeue at full
      for (int i = 0; i < 32; i++) step(1'b1, 5'(i ^ 5'd9), 1'b0, 1'b0);
      step(1'b0, 5'd0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 1'b0, 1'b0);
      step(1'b1, 5'd21, 1'b1, 1'b0);
      check("simfull_enq_ready", enq_ready, 0);
      check("simfull_deq_valid", deq_valid, 1);
      check("simfull_mem_we", mem_we, 0);
      step(1'b1, 5'd21, 1'b0, 1'b0);
      check("simfull_count_after", count, 31);
      check("simfull_state_after", fsm_state, 1);
      check("simfull_retry_mem_we", mem_we, 1);
      step(1'b0, 5'd0, 1'b0, 1'b0);
      check("simfull_refill_count", count, 32);
      drain("simfull_drain");

      // Flush with a concurrent enqueue offer
      for (int i = 0; i < 5; i++) step(1'b1, 5'(i + 1), 1'b0, 1'b0);
      step(1'b1, 5'd20, 1'b0, 1'b1);
      check("flush_enq_ready", enq_ready, 0);
      check("flush_mem_we", mem_we, 0);
      check("flush_deq_valid", deq_valid, 0);
      exp_q.delete();
      step(1'b0, 5'd0, 1'b0, 1'b0);
      check("postflush_count", count, 0);
      check("postflush_deq_valid", deq_valid, 0);
      check("postflush_state", fsm_state, 3);
      step(1'b1, 5'd9, 1'b0, 1'b0);
      check("postflush_empty_state", fsm_state, 0);
      check("postflush_mem_we", mem_we, 1);
      check("postflush_mem_dest", mem_dest, 0);
      step(1'b0, 5'd0, 1'b1, 1'b0);
      check("postflush_no_stale", deq_valid, 0);
      step(1'b0, 5'd0, 1'b1, 1'b0);
      check("postflush_tag9_valid", deq_valid, 1);
      step(1'b0, 5'd0, 1'b0, 1'b0);
      check("postflush_final_count", count, 0);
      check("postflush_queue_left", exp_q.size(), 0);
`ifdef ORDER_QUEUE_HWM_EN
      check("hwm_kept_over_flush", hwm, 32);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
